// File: rtl/mips_io_port_if.sv
// Bus-side and port-side signals of the mips_io_port memory-mapped I/O block.
// The slave modport is the responder's view; the master modport is the
// processor / external-world view used by whoever drives the block.
interface mips_io_port_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_WIDTH   = 8
);
  // Processor memory-stage side
  logic [31:0]           addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  sel;

  // External side
  logic [IN_WIDTH-1:0]   port_in;
  logic [DATA_WIDTH-1:0] port_out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  irq;

  modport slave (
    input  addr, wr_en, rd_en, wr_data, port_in, out_ready,
    output rd_data, sel, port_out, out_valid, irq
  );

  modport master (
    output addr, wr_en, rd_en, wr_data, port_in, out_ready,
    input  rd_data, sel, port_out, out_valid, irq
  );
endinterface

// File: rtl/mips_io_port.sv
// Memory-mapped I/O responder for the MIPS data-memory stage.
// Register map (byte offsets from BASE_ADDR, addr[3:2] selects, addr[1:0] ignored):
//   0x0 OUT    R/W  last accepted store, driven on port_out
//   0x4 IN     RO   synchronized port_in, zero-extended
//   0x8 STATUS RO   bit0 IN_CHANGED, bit1 OVERRUN (both read-to-clear),
//                   bit2 out_valid (live)
//   0xC CTRL   R/W  bit0 IRQ_EN
//
// Output handshake: port_out carries data whenever out_valid is high; a
// transfer happens on every rising edge where out_valid && out_ready. After a
// transfer out_valid falls unless a store is accepted in that same cycle, in
// which case it stays high with the new data. port_out holds its value after
// a transfer. A store arriving while out_valid && !out_ready is dropped and
// sets OVERRUN.
module mips_io_port #(
  parameter int          DATA_WIDTH = 32,
  parameter int          IN_WIDTH   = 8,
  parameter logic [31:0] BASE_ADDR  = 32'h1001_0000
) (
  input logic clk,
  input logic reset,
  mips_io_port_if.slave bus
);

  localparam logic [1:0] REG_OUT    = 2'd0;
  localparam logic [1:0] REG_IN     = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  // State registers
  logic [DATA_WIDTH-1:0] port_out_q,   port_out_d;
  logic                  out_valid_q,  out_valid_d;
  logic                  in_changed_q, in_changed_d;
  logic                  overrun_q,    overrun_d;
  logic                  irq_en_q,     irq_en_d;
  logic                  irq_q,        irq_d;
  logic [IN_WIDTH-1:0]   sync1_q,      sync1_d;
  logic [IN_WIDTH-1:0]   sync2_q,      sync2_d;
  logic [IN_WIDTH-1:0]   in_last_q,    in_last_d;

  // Decode / event signals
  logic       sel_hit;
  logic [1:0] reg_idx;
  logic       wr_out;
  logic       wr_ctrl;
  logic       rd_status;
  logic       transfer;
  logic       store_accept;
  logic       store_drop;
  logic       in_chg;

  // Read-mux helpers
  logic [DATA_WIDTH-1:0] in_ext;
  logic [DATA_WIDTH-1:0] status_word;
  logic [DATA_WIDTH-1:0] ctrl_word;
  logic [DATA_WIDTH-1:0] rd_data_c;

  // Byte-lane bits of the address do not affect register selection.
  logic unused_addr_bits;
  assign unused_addr_bits = &{1'b0, bus.addr[1:0]};

  // Address decode and bus event qualification
  always_comb begin
    sel_hit      = (bus.addr[31:4] == BASE_ADDR[31:4]);
    reg_idx      = bus.addr[3:2];
    wr_out       = sel_hit && bus.wr_en && (reg_idx == REG_OUT);
    wr_ctrl      = sel_hit && bus.wr_en && (reg_idx == REG_CTRL);
    rd_status    = sel_hit && bus.rd_en && (reg_idx == REG_STATUS);
    transfer     = out_valid_q && bus.out_ready;
    store_accept = wr_out && (!out_valid_q || bus.out_ready);
    store_drop   = wr_out && out_valid_q && !bus.out_ready;
    in_chg       = (sync2_q != in_last_q);
  end

  // Next-state logic for output port, flags, control and synchronizer
  always_comb begin
    port_out_d   = port_out_q;
    out_valid_d  = out_valid_q;
    in_changed_d = in_changed_q;
    overrun_d    = overrun_q;
    irq_en_d     = irq_en_q;

    // Output register: accepted store wins over a plain transfer.
    if (store_accept) begin
      port_out_d  = bus.wr_data;
      out_valid_d = 1'b1;
    end else if (transfer) begin
      out_valid_d = 1'b0;
    end

    // Sticky flags: a set event in the clearing cycle keeps the flag set.
    if (in_chg) begin
      in_changed_d = 1'b1;
    end else if (rd_status) begin
      in_changed_d = 1'b0;
    end

    if (store_drop) begin
      overrun_d = 1'b1;
    end else if (rd_status) begin
      overrun_d = 1'b0;
    end

    if (wr_ctrl) begin
      irq_en_d = bus.wr_data[0];
    end

    // Interrupt follows the flag value being loaded at this edge.
    irq_d = irq_en_q && in_changed_d;

    // Two-flop synchronizer plus history flop for change detection.
    sync1_d   = bus.port_in;
    sync2_d   = sync1_q;
    in_last_d = sync2_q;
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      port_out_q   <= '0;
      out_valid_q  <= 1'b0;
      in_changed_q <= 1'b0;
      overrun_q    <= 1'b0;
      irq_en_q     <= 1'b0;
      irq_q        <= 1'b0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      in_last_q    <= '0;
    end else begin
      port_out_q   <= port_out_d;
      out_valid_q  <= out_valid_d;
      in_changed_q <= in_changed_d;
      overrun_q    <= overrun_d;
      irq_en_q     <= irq_en_d;
      irq_q        <= irq_d;
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      in_last_q    <= in_last_d;
    end
  end

  // Zero-wait-state read mux; returns 0 when not selected or not reading
  always_comb begin
    in_ext                  = '0;
    in_ext[IN_WIDTH-1:0]    = sync2_q;
    status_word             = '0;
    status_word[2:0]        = {out_valid_q, overrun_q, in_changed_q};
    ctrl_word               = '0;
    ctrl_word[0]            = irq_en_q;
    rd_data_c               = '0;
    if (sel_hit && bus.rd_en) begin
      case (reg_idx)
        REG_OUT:    rd_data_c = port_out_q;
        REG_IN:     rd_data_c = in_ext;
        REG_STATUS: rd_data_c = status_word;
        REG_CTRL:   rd_data_c = ctrl_word;
        default:    rd_data_c = '0;
      endcase
    end
  end

  assign bus.rd_data   = rd_data_c;
  assign bus.sel       = sel_hit;
  assign bus.port_out  = port_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.irq       = irq_q;

endmodule

// File: doc/mips_io_port.md
Name: mips_io_port

Overview:
- Memory-mapped I/O responder for the MIPS_Processor data-memory stage.
- Turns processor stores into a handshaked parallel output (port_out, with valid/ready).
- Brings an asynchronous external input (port_in) into the clock domain through a synchronizer, and detects changes on it.
- Exposes status and control registers, and an optional level interrupt, to processor loads.

Parameters:
- DATA_WIDTH, 32, processor data-bus width.
- IN_WIDTH, 8, width of external input port; zero-extended on reads.
- BASE_ADDR, 32'h1001_0000, block base address; must be 16-byte aligned.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from the memory stage.
- wr_en  in  1  store strobe, one cycle per store.
- rd_en  in  1  load strobe, one cycle per load.
- wr_data  in  DATA_WIDTH  store data.
- rd_data  out  DATA_WIDTH  load data, combinational.
- sel  out  1  high when addr hits this block; used by the memory mux.
- port_in  in  IN_WIDTH  asynchronous external input.
- port_out  out  DATA_WIDTH  registered output data.
- out_valid  out  1  port_out holds data not yet accepted.
- out_ready  in  1  external sink accepts port_out.
- irq  out  1  level interrupt request.

Behaviour:
- Address decode:
  - sel = (addr[31:4] == BASE_ADDR[31:4]).
  - Register select is addr[3:2]; addr[1:0] is ignored.
- Register map:
  - 0x0 OUT: R/W; value is port_out.
  - 0x4 IN: RO; zero-extended synchronized input.
  - 0x8 STATUS: RO, read-to-clear. bit0 IN_CHANGED, bit1 OVERRUN, bit2 out_valid (live, not cleared).
  - 0xC CTRL: R/W; bit0 IRQ_EN, other bits read 0.
- Reset (reset low, asynchronous):
  - port_out, out_valid, IN_CHANGED, OVERRUN, CTRL, both sync flops and in_last all go to 0.
  - irq = 0.
  - rd_data and sel are combinational, not reset.
- Read path:
  - rd_data = selected register when sel && rd_en, else 0.
  - Zero wait states.
- Store to OUT (sel && wr_en && addr[3:2]==0):
  - If !out_valid, or out_valid && out_ready: at the edge, port_out <= wr_data and out_valid <= 1.
  - If out_valid && !out_ready: store is dropped, port_out is unchanged, OVERRUN <= 1.
- Output handshake:
  - Transfer occurs on any edge with out_valid && out_ready.
  - With no accepted store in that cycle, out_valid <= 0.
  - port_out holds its value after transfer.
  - Transfer plus accepted store in the same cycle: out_valid stays 1 with new data.
- Store to IN or STATUS is ignored. Store to CTRL writes bit0 only.
- Input synchronizer:
  - sync1 <= port_in; sync2 <= sync1; in_last <= sync2.
  - IN reads sync2, so a change is visible after the 2nd edge.
  - chg = (sync2 != in_last); IN_CHANGED sets at the 3rd edge after a stable change.
  - A nonzero port_in after reset therefore sets IN_CHANGED.
- STATUS read-to-clear:
  - At the edge ending a cycle with sel && rd_en && addr[3:2]==2, IN_CHANGED and OVERRUN clear.
  - Read data returned in that cycle shows the pre-clear values.
  - A set event (chg or dropped store) in the same cycle wins; the flag stays 1.
- irq: registered. irq <= CTRL.IRQ_EN & IN_CHANGED_next; deasserts the edge after the clear.
- Simultaneous wr_en and rd_en: both are serviced independently.
- Reset mid-handshake: out_valid drops immediately; the sink must not sample after reset falls.

Test Plan:
- Reset: hold reset=0 with port_in=3 -> all outputs 0, irq 0; release reset -> IN reads 3 after 2 edges, STATUS reads 0x1 after 3 edges.
- Output handshake: out_ready=0, store 0xA5 to BASE+0 -> port_out=0xA5, out_valid=1 next cycle. Raise out_ready -> out_valid=0 after one edge, port_out stays 0xA5.
- Overrun: out_ready=0, store 0x11 then 0x22 -> port_out=0x11 and STATUS=0x6. Read STATUS again -> 0x4.
- Back-to-back: out_ready=1, stores 0x1,0x2,0x3 on consecutive cycles -> port_out steps 1,2,3, out_valid stays 1, OVERRUN=0.
- Change and interrupt: CTRL=1, port_in 3->7 -> irq=1 within 4 edges. Read STATUS returns 0x1 -> irq=0 next edge. Change port_in during the read cycle -> IN_CHANGED remains 1.
- Decode: read BASE+0x10 or BASE-4 -> sel=0, rd_data=0. Store there -> no register changes.
